// File: rtl/pi_cycle_ctl.sv
// pi_cycle_ctl: KL10 priority-interrupt cycle sequencer (level arbitration, PI cycle handshake, held levels)
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   pi_on, pi_gen_on  PI system enable and per-level enables (bit 1 = highest priority)
//   pi_req            raw level requests, registered once before arbitration
//   ok_to_interrupt   microcode at an instruction boundary
//   pi_cycle_done     microcode finished the PI cycle (pulse)
//   pi_dismiss        dismiss the highest-priority held level (pulse)
//   pi_ready          interrupt pending
//   pi_cycle          PI cycle in progress; PCplus1inh mirrors it
//   pi_level          level being serviced, 0 when idle
//   pi_hold           held (in-progress) levels
//   pi_timeout        one-clock pulse when a PI cycle is aborted
module pi_cycle_ctl #(
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pi_on,
    input  logic [1:7] pi_gen_on,
    input  logic [1:7] pi_req,
    input  logic       ok_to_interrupt,
    input  logic       pi_cycle_done,
    input  logic       pi_dismiss,
    output logic       pi_ready,
    output logic       pi_cycle,
    output logic       PCplus1inh,
    output logic [0:2] pi_level,
    output logic [1:7] pi_hold,
    output logic       pi_timeout
);
    typedef enum logic {IDLE, CYCLE} state_t;
    state_t          state_q;
    logic [1:7]      req_q, hold_q, hold_d, eligible;
    logic [CNTW-1:0] cnt_q;
    logic [2:0]      level_q, best, top_hold;
    logic            cycle_q, timeout_q, done_ev;
    assign eligible = req_q & pi_gen_on & {7{pi_on}};
    assign done_ev  = state_q == CYCLE && pi_cycle_done;
    // Scanning from 7 down to 1 leaves the lowest-numbered (highest-priority) set bit.
    always_comb begin
        best     = '0;
        top_hold = '0;
        for (int i = 7; i >= 1; i--) begin
            if (eligible[i]) best = 3'(i);
            if (hold_q[i]) top_hold = 3'(i);
        end
    end
    // Dismiss acts on the pre-edge top held level; a level completing on the same edge is set afterwards.
    always_comb begin
        hold_d = hold_q;
        for (int i = 1; i <= 7; i++) begin
            if (pi_dismiss && top_hold == 3'(i)) hold_d[i] = 1'b0;
            if (done_ev && level_q == 3'(i)) hold_d[i] = 1'b1;
        end
    end
    assign pi_ready = state_q == IDLE && best != 3'd0 && (top_hold == 3'd0 || best < top_hold);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            cycle_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            req_q     <= pi_req;
            hold_q    <= hold_d;
            timeout_q <= 1'b0;
            if (state_q == IDLE) begin
                if (pi_ready && ok_to_interrupt) begin
                    state_q <= CYCLE;
                    level_q <= best;
                    cnt_q   <= '0;
                    cycle_q <= 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (pi_cycle_done || cnt_q == CNTW'(TIMEOUT - 1)) begin
                    state_q   <= IDLE;
                    level_q   <= '0;
                    cycle_q   <= 1'b0;
                    timeout_q <= !pi_cycle_done;
                end
            end
        end
    end
    assign pi_cycle   = cycle_q;
    assign PCplus1inh = cycle_q;
    assign pi_level   = level_q;
    assign pi_hold    = hold_q;
    assign pi_timeout = timeout_q;
endmodule

// File: tb/tb_pi_cycle_ctl.sv
// tb_pi_cycle_ctl: directed and randomized checks of pi_cycle_ctl against a behavioural model
module tb_pi_cycle_ctl;
    localparam int TO = 64;
    logic       clk = 1'b0, reset = 1'b1, pi_on = 1'b0, ok_to_interrupt = 1'b0;
    logic       pi_cycle_done = 1'b0, pi_dismiss = 1'b0;
    logic [1:7] pi_gen_on = '0, pi_req = '0, pi_hold;
    logic       pi_ready, pi_cycle, PCplus1inh, pi_timeout;
    logic [0:2] pi_level;
    int checks = 0, errors = 0;
    logic [1:7] m_req_q = '0, m_hold = '0;
    bit         m_busy = 0, m_to = 0;
    int         m_level = 0, m_age = 0;

    pi_cycle_ctl #(.TIMEOUT(TO), .CNTW(7)) dut (
        .clk(clk), .reset(reset), .pi_on(pi_on), .pi_gen_on(pi_gen_on), .pi_req(pi_req),
        .ok_to_interrupt(ok_to_interrupt), .pi_cycle_done(pi_cycle_done), .pi_dismiss(pi_dismiss),
        .pi_ready(pi_ready), .pi_cycle(pi_cycle), .PCplus1inh(PCplus1inh), .pi_level(pi_level),
        .pi_hold(pi_hold), .pi_timeout(pi_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [1:7] bitv(input int n);
        logic [1:7] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic int lowest(input logic [1:7] v);
        for (int i = 1; i <= 7; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic bit model_ready();
        int b, th;
        b  = lowest(m_req_q & pi_gen_on & {7{pi_on}});
        th = lowest(m_hold);
        return !m_busy && b != 0 && (th == 0 || b < th);
    endfunction

    // Advance the model by one clock edge using the inputs present just before that edge.
    task automatic model_edge();
        logic [1:7] nh;
        int th;
        bit rdy;
        if (reset) begin
            m_req_q = '0; m_hold = '0; m_busy = 0; m_to = 0; m_level = 0; m_age = 0;
            return;
        end
        rdy = model_ready();
        th  = lowest(m_hold);
        nh  = m_hold;
        if (pi_dismiss && th != 0) nh[th] = 1'b0;
        m_to = 0;
        if (!m_busy) begin
            if (rdy && ok_to_interrupt) begin
                m_busy  = 1;
                m_level = lowest(m_req_q & pi_gen_on & {7{pi_on}});
                m_age   = 0;
            end
        end else if (pi_cycle_done) begin
            nh[m_level] = 1'b1;
            m_busy = 0; m_level = 0;
        end else if (m_age == TO - 1) begin
            m_busy = 0; m_level = 0; m_to = 1;
        end else m_age++;
        m_hold  = nh;
        m_req_q = pi_req;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("pi_cycle", 32'(pi_cycle), 32'(m_busy));
        chk("PCplus1inh", 32'(PCplus1inh), 32'(m_busy));
        chk("pi_level", 32'(pi_level), 32'(m_level));
        chk("pi_hold", 32'(pi_hold), 32'(m_hold));
        chk("pi_timeout", 32'(pi_timeout), 32'(m_to));
        chk("pi_ready", 32'(pi_ready), 32'(model_ready()));
    endtask

    task automatic clear_holds();
        pi_dismiss = 1'b1;
        repeat (7) step();
        pi_dismiss = 1'b0;
        chk("holds_cleared", 32'(pi_hold), 32'd0);
    endtask

    task automatic run_level(input int n);
        pi_req = bitv(n); ok_to_interrupt = 1'b1;
        step(); step();
        chk("run_level", 32'(pi_level), 32'(n));
        ok_to_interrupt = 1'b0; pi_req = '0; pi_cycle_done = 1'b1;
        step();
        pi_cycle_done = 1'b0;
    endtask

    initial begin
        step(); step();
        chk("reset_level", 32'(pi_level), 32'd0);
        reset = 1'b0;
        // Single request, two-edge latency, then done sets the hold bit.
        pi_on = 1'b1; pi_gen_on = 7'h7F; pi_req = bitv(3); ok_to_interrupt = 1'b1;
        step();
        chk("lat_not_yet", 32'(pi_cycle), 32'd0);
        step();
        chk("lat_cycle", 32'(pi_cycle), 32'd1);
        chk("lat_level", 32'(pi_level), 32'd3);
        pi_req = '0; ok_to_interrupt = 1'b0; pi_cycle_done = 1'b1;
        step();
        pi_cycle_done = 1'b0;
        chk("done_hold3", 32'(pi_hold), 32'(bitv(3)));
        clear_holds();
        // Simultaneous requests 5 and 2; held level 2 masks 5 until dismissed.
        pi_req = bitv(5) | bitv(2); ok_to_interrupt = 1'b1;
        step(); step();
        chk("prio_level2", 32'(pi_level), 32'd2);
        ok_to_interrupt = 1'b0; pi_req = bitv(5); pi_cycle_done = 1'b1;
        step();
        pi_cycle_done = 1'b0;
        step();
        chk("masked_ready", 32'(pi_ready), 32'd0);
        pi_dismiss = 1'b1;
        step();
        pi_dismiss = 1'b0;
        chk("unmasked_ready", 32'(pi_ready), 32'd1);
        ok_to_interrupt = 1'b1;
        step();
        chk("level5", 32'(pi_level), 32'd5);
        ok_to_interrupt = 1'b0; pi_req = '0; pi_cycle_done = 1'b1;
        step();
        pi_cycle_done = 1'b0;
        clear_holds();
        // Higher priority preempts a held lower level.
        run_level(4);
        run_level(1);
        chk("hold_1_4", 32'(pi_hold), 32'(bitv(1) | bitv(4)));
        pi_dismiss = 1'b1;
        step();
        pi_dismiss = 1'b0;
        chk("dismiss_top", 32'(pi_hold), 32'(bitv(4)));
        clear_holds();
        // Timeout without done.
        run_level(7);
        pi_req = bitv(6); ok_to_interrupt = 1'b1;
        step(); step();
        ok_to_interrupt = 1'b0; pi_req = '0;
        repeat (TO - 1) step();
        chk("to_still_cycle", 32'(pi_cycle), 32'd1);
        step();
        chk("to_pulse", 32'(pi_timeout), 32'd1);
        chk("to_cycle_off", 32'(pi_cycle), 32'd0);
        chk("to_hold_kept", 32'(pi_hold), 32'(bitv(7)));
        step();
        chk("to_pulse_end", 32'(pi_timeout), 32'd0);
        clear_holds();
        // Done and dismiss on the same edge.
        run_level(6);
        pi_req = bitv(2); ok_to_interrupt = 1'b1;
        step(); step();
        ok_to_interrupt = 1'b0; pi_req = '0; pi_cycle_done = 1'b1; pi_dismiss = 1'b1;
        step();
        pi_cycle_done = 1'b0; pi_dismiss = 1'b0;
        chk("done_dismiss", 32'(pi_hold), 32'(bitv(2)));
        clear_holds();
        // Reset during a cycle.
        pi_req = bitv(3); ok_to_interrupt = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0; ok_to_interrupt = 1'b0;
        chk("rst_cycle", 32'(pi_cycle), 32'd0);
        chk("rst_hold", 32'(pi_hold), 32'd0);
        // PI system off masks everything.
        pi_on = 1'b0; pi_req = 7'h7F; ok_to_interrupt = 1'b1;
        step(); step();
        chk("pi_off_ready", 32'(pi_ready), 32'd0);
        // Randomized phase.
        for (int n = 0; n < 4000; n++) begin
            reset           = ($urandom_range(0, 499) == 0);
            pi_on           = ($urandom_range(0, 9) != 0);
            pi_gen_on       = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h7F;
            pi_req          = ($urandom_range(0, 2) == 0) ? 7'($urandom) : '0;
            ok_to_interrupt = $urandom_range(0, 1) == 1;
            pi_cycle_done   = ($urandom_range(0, 39) == 0);
            pi_dismiss      = ($urandom_range(0, 14) == 0);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
